// File: rtl/reg_int_bank.sv
// reg_int_bank: host register bank with control, command, W1C status/irq and RMON read FSM.
module reg_int_bank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NUM_CTRL = 35,
  parameter logic [NUM_CTRL*DATA_W-1:0] REG_INIT = '0,
  parameter int RMON_W = 32,
  parameter int RMON_AW = 6,
  parameter int TIMEOUT = 255
) (
  input  logic                         Clk_reg,
  input  logic                         Reset_n,
  input  logic                         CSB,
  input  logic                         WRB,
  input  logic [ADDR_W-1:0]            CA,
  input  logic [DATA_W-1:0]            CD_in,
  output logic [DATA_W-1:0]            CD_out,
  output logic [NUM_CTRL*DATA_W-1:0]   ctrl_regs,
  output logic [DATA_W-1:0]            cmd_pulse,
  input  logic [DATA_W-1:0]            status_in,
  output logic                         irq,
  output logic [RMON_AW-1:0]           CPU_rd_addr,
  output logic                         CPU_rd_apply,
  input  logic                         CPU_rd_grant,
  input  logic [RMON_W-1:0]            CPU_rd_dout
);
  localparam int IW = ADDR_W - 1;
  localparam int NW = RMON_W / DATA_W;
  localparam int B = NUM_CTRL;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] I_CMD = IW'(B);
  localparam logic [IW-1:0] I_STAT = IW'(B + 1);
  localparam logic [IW-1:0] I_MASK = IW'(B + 2);
  localparam logic [IW-1:0] I_RADDR = IW'(B + 3);
  localparam logic [IW-1:0] I_RSTAT = IW'(B + 4);
  localparam logic [IW-1:0] I_RDATA = IW'(B + 5);

  if (B + 5 + NW > 2 ** (ADDR_W - 1)) begin : g_map_chk
    $error("register map does not fit the host address space");
  end
  if (RMON_W % DATA_W != 0) begin : g_rmon_chk
    $error("RMON_W must be a multiple of DATA_W");
  end
  if (TIMEOUT < 1) begin : g_to_chk
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  logic [IW-1:0]     idx;
  logic              wr_lvl, wr_lvl_q, wr_edge, rd;
  logic              unused_ca0;
  logic [DATA_W-1:0] ctrl_q [NUM_CTRL];
  logic [DATA_W-1:0] cmd_q, status_q, mask_q, cd_out_q, rd_word;
  logic              irq_q;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d, to_q, to_d;
  logic [RMON_AW-1:0] addr_q, addr_d;
  logic [RMON_W-1:0] snap_q, snap_d;

  assign idx = CA[ADDR_W-1:1];
  assign unused_ca0 = CA[0];
  assign wr_lvl = !CSB && !WRB;
  assign wr_edge = wr_lvl && !wr_lvl_q;
  assign rd = !CSB && WRB;

  for (genvar i = 0; i < NUM_CTRL; i++) begin : g_ctrl
    assign ctrl_regs[i*DATA_W +: DATA_W] = ctrl_q[i];
  end

  assign CD_out = cd_out_q;
  assign cmd_pulse = cmd_q;
  assign irq = irq_q;
  assign CPU_rd_addr = addr_q;
  assign CPU_rd_apply = state_q == REQ;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CTRL; i++) if (idx == IW'(i)) rd_word = ctrl_q[i];
    for (int i = 0; i < NW; i++) if (idx == I_RDATA + IW'(i)) rd_word = snap_q[i*DATA_W +: DATA_W];
    if (idx == I_STAT) rd_word = status_q;
    if (idx == I_MASK) rd_word = mask_q;
    if (idx == I_RADDR) rd_word = DATA_W'(addr_q);
    if (idx == I_RSTAT) rd_word = DATA_W'({to_q, done_q, state_q == REQ});
  end

  // A relaunch is only accepted from IDLE, so a busy read keeps its address and snapshot.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    done_d = done_q;
    to_d = to_q;
    addr_d = addr_q;
    snap_d = snap_q;
    case (state_q)
      IDLE: if (wr_edge && idx == I_RADDR) begin
        state_d = REQ;
        addr_d = CD_in[RMON_AW-1:0];
        done_d = 1'b0;
        to_d = 1'b0;
        cnt_d = '0;
      end
      REQ: if (CPU_rd_grant) begin
        state_d = DONE;
        snap_d = CPU_rd_dout;
        done_d = 1'b1;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d = IDLE;
        to_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_reg or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= REG_INIT[i*DATA_W +: DATA_W];
      wr_lvl_q <= 1'b0;
      cmd_q <= '0;
      status_q <= '0;
      mask_q <= '0;
      irq_q <= 1'b0;
      cd_out_q <= '0;
      state_q <= IDLE;
      cnt_q <= '0;
      done_q <= 1'b0;
      to_q <= 1'b0;
      addr_q <= '0;
      snap_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CTRL; i++) if (wr_lvl && idx == IW'(i)) ctrl_q[i] <= CD_in;
      wr_lvl_q <= wr_lvl;
      cmd_q <= (wr_edge && idx == I_CMD) ? CD_in : '0;
      status_q <= (status_q & ~((wr_edge && idx == I_STAT) ? CD_in : '0)) | status_in;
      mask_q <= (wr_lvl && idx == I_MASK) ? CD_in : mask_q;
      irq_q <= |(status_q & mask_q);
      cd_out_q <= rd ? rd_word : cd_out_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      to_q <= to_d;
      addr_q <= addr_d;
      snap_q <= snap_d;
    end
  end
endmodule

// File: tb/tb_reg_int_bank.sv
// tb_reg_int_bank: directed table and sequence checks for reg_int_bank.
module tb_reg_int_bank;
  function automatic logic [559:0] mk_init();
    logic [559:0] v;
    for (int i = 0; i < 35; i++) v[i*16 +: 16] = 16'hA500 + 16'(i);
    return v;
  endfunction
  localparam logic [559:0] INIT = mk_init();

  logic clk = 1'b0, rst_n, csb, wrb, irq, apply, grant;
  logic [7:0] ca;
  logic [15:0] cd_in, cd_out, cmd_pulse, status_in, rdata;
  logic [559:0] ctrl_regs;
  logic [5:0] rd_addr;
  logic [31:0] dout;
  int n_cmp = 0, n_err = 0, n_app;

  typedef struct {
    logic        wr;
    logic [6:0]  idx;
    logic [15:0] data;
  } vec_t;
  vec_t tbl [18];

  reg_int_bank #(.REG_INIT(INIT), .TIMEOUT(8)) dut (
    .Clk_reg(clk), .Reset_n(rst_n), .CSB(csb), .WRB(wrb), .CA(ca), .CD_in(cd_in),
    .CD_out(cd_out), .ctrl_regs(ctrl_regs), .cmd_pulse(cmd_pulse), .status_in(status_in),
    .irq(irq), .CPU_rd_addr(rd_addr), .CPU_rd_apply(apply), .CPU_rd_grant(grant),
    .CPU_rd_dout(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [6:0] idx, input logic [15:0] d);
    csb = 1'b0; wrb = 1'b0; ca = {idx, 1'b0}; cd_in = d;
    step();
    csb = 1'b1; wrb = 1'b1;
    step();
  endtask

  task automatic rd(input logic [7:0] a, output logic [15:0] d);
    csb = 1'b0; wrb = 1'b1; ca = a;
    step();
    csb = 1'b1;
    d = cd_out;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 7'd0,   16'h1234};
    tbl[1]  = '{1'b0, 7'd0,   16'h1234};
    tbl[2]  = '{1'b0, 7'd1,   16'hA501};
    tbl[3]  = '{1'b1, 7'd34,  16'hBEEF};
    tbl[4]  = '{1'b0, 7'd34,  16'hBEEF};
    tbl[5]  = '{1'b0, 7'd33,  16'hA521};
    tbl[6]  = '{1'b0, 7'd35,  16'h0000};
    tbl[7]  = '{1'b1, 7'd37,  16'h00F0};
    tbl[8]  = '{1'b0, 7'd37,  16'h00F0};
    tbl[9]  = '{1'b0, 7'd38,  16'h0000};
    tbl[10] = '{1'b0, 7'd39,  16'h0000};
    tbl[11] = '{1'b0, 7'd40,  16'h0000};
    tbl[12] = '{1'b0, 7'd41,  16'h0000};
    tbl[13] = '{1'b1, 7'd42,  16'hFFFF};
    tbl[14] = '{1'b0, 7'd42,  16'h0000};
    tbl[15] = '{1'b1, 7'd127, 16'h1111};
    tbl[16] = '{1'b0, 7'd127, 16'h0000};
    tbl[17] = '{1'b0, 7'd36,  16'h0000};

    rst_n = 1'b0; csb = 1'b1; wrb = 1'b1; ca = '0; cd_in = '0;
    status_in = '0; grant = 1'b0; dout = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("reset irq", 32'(irq), 0);
    chk("reset apply", 32'(apply), 0);
    chk("reset cd_out", 32'(cd_out), 0);
    chk("reset cmd", 32'(cmd_pulse), 0);
    n_cmp++;
    if (ctrl_regs !== INIT) begin
      n_err++;
      $display("FAIL reset ctrl_regs: got %0h expected %0h", ctrl_regs, INIT);
    end
    for (int i = 0; i < 35; i++) begin
      rd({7'(i), 1'b0}, rdata);
      chk($sformatf("reset ctrl%0d", i), 32'(rdata), 32'(16'hA500 + 16'(i)));
    end
    rd(8'h03, rdata);
    chk("ca bit0 ignored", 32'(rdata), 32'h0000A501);
    rd({7'd39, 1'b0}, rdata);
    chk("reset rmon_stat", 32'(rdata), 0);

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].wr) wr(tbl[i].idx, tbl[i].data);
      else begin
        rd({tbl[i].idx, 1'b0}, rdata);
        chk($sformatf("tbl%0d idx%0d", i, tbl[i].idx), 32'(rdata), 32'(tbl[i].data));
      end
    end

    csb = 1'b0; wrb = 1'b0; ca = {7'd35, 1'b0}; cd_in = 16'h0005;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("cmd cycle%0d", k), 32'(cmd_pulse), k == 0 ? 32'h5 : 32'h0);
    end
    csb = 1'b1; wrb = 1'b1;
    step();
    chk("cmd after", 32'(cmd_pulse), 0);
    rd({7'd35, 1'b0}, rdata);
    chk("cmd reads 0", 32'(rdata), 0);

    wr(7'd37, 16'h0008);
    status_in = 16'h0008;
    step();
    status_in = '0;
    chk("irq not yet", 32'(irq), 0);
    step();
    chk("irq rises", 32'(irq), 1);
    rd({7'd36, 1'b0}, rdata);
    chk("status set", 32'(rdata), 32'h8);
    csb = 1'b0; wrb = 1'b0; ca = {7'd36, 1'b0}; cd_in = 16'h0008; status_in = 16'h0008;
    step();
    csb = 1'b1; wrb = 1'b1; status_in = '0;
    step();
    rd({7'd36, 1'b0}, rdata);
    chk("set wins clear", 32'(rdata), 32'h8);
    chk("irq held", 32'(irq), 1);
    wr(7'd36, 16'h0008);
    chk("irq cleared", 32'(irq), 0);
    rd({7'd36, 1'b0}, rdata);
    chk("status cleared", 32'(rdata), 0);

    csb = 1'b0; wrb = 1'b0; ca = {7'd38, 1'b0}; cd_in = 16'h0015;
    step();
    csb = 1'b1; wrb = 1'b1;
    chk("grant addr", 32'(rd_addr), 32'h15);
    n_app = apply ? 1 : 0;
    repeat (3) begin
      step();
      if (apply) n_app++;
    end
    grant = 1'b1; dout = 32'hDEADBEEF;
    step();
    grant = 1'b0; dout = '0;
    chk("apply dropped", 32'(apply), 0);
    chk("apply cycles grant", 32'(n_app), 4);
    rd({7'd39, 1'b0}, rdata);
    chk("rmon_stat done", 32'(rdata), 32'h2);
    rd({7'd40, 1'b0}, rdata);
    chk("rmon lo", 32'(rdata), 32'hBEEF);
    rd({7'd41, 1'b0}, rdata);
    chk("rmon hi", 32'(rdata), 32'hDEAD);
    grant = 1'b1; dout = 32'h12345678;
    step();
    step();
    grant = 1'b0; dout = '0;
    chk("stray grant apply", 32'(apply), 0);
    rd({7'd40, 1'b0}, rdata);
    chk("stray grant ignored", 32'(rdata), 32'hBEEF);

    csb = 1'b0; wrb = 1'b0; ca = {7'd38, 1'b0}; cd_in = 16'h002A;
    step();
    csb = 1'b1; wrb = 1'b1;
    n_app = apply ? 1 : 0;
    for (int k = 1; k < 20; k++) begin
      if (k == 2) begin
        csb = 1'b0; wrb = 1'b0; ca = {7'd38, 1'b0}; cd_in = 16'h0007;
      end
      step();
      if (k == 2) begin
        csb = 1'b1; wrb = 1'b1;
        chk("relaunch ignored addr", 32'(rd_addr), 32'h2A);
      end
      if (apply) n_app++;
    end
    chk("apply cycles timeout", 32'(n_app), 8);
    rd({7'd39, 1'b0}, rdata);
    chk("rmon_stat timeout", 32'(rdata), 32'h4);
    rd({7'd38, 1'b0}, rdata);
    chk("rmon_addr kept", 32'(rdata), 32'h2A);
    rd({7'd40, 1'b0}, rdata);
    chk("snap lo kept", 32'(rdata), 32'hBEEF);
    rd({7'd41, 1'b0}, rdata);
    chk("snap hi kept", 32'(rdata), 32'hDEAD);

    status_in = 16'h0008;
    step();
    status_in = '0;
    step();
    chk("irq before reset", 32'(irq), 1);
    csb = 1'b0; wrb = 1'b0; ca = {7'd38, 1'b0}; cd_in = 16'h0011;
    step();
    csb = 1'b1; wrb = 1'b1;
    chk("apply before reset", 32'(apply), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset apply", 32'(apply), 0);
    chk("mid reset addr", 32'(rd_addr), 0);
    chk("mid reset irq", 32'(irq), 0);
    chk("mid reset cd_out", 32'(cd_out), 0);
    n_cmp++;
    if (ctrl_regs !== INIT) begin
      n_err++;
      $display("FAIL mid reset ctrl_regs: got %0h expected %0h", ctrl_regs, INIT);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("post reset apply", 32'(apply), 0);
    rd({7'd39, 1'b0}, rdata);
    chk("post reset rmon_stat", 32'(rdata), 0);
    rd({7'd40, 1'b0}, rdata);
    chk("post reset snap", 32'(rdata), 0);
    rd({7'd36, 1'b0}, rdata);
    chk("post reset status", 32'(rdata), 0);
    rd({7'd37, 1'b0}, rdata);
    chk("post reset mask", 32'(rdata), 0);
    rd({7'd0, 1'b0}, rdata);
    chk("post reset ctrl0", 32'(rdata), 32'hA500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
